tlb_unit: RTL and testbench

- Joint TLB for the MMU. Sits directly downstream of the segment mapper.
- When the mapper flags a mapped segment (useg/kseg2/kseg3), this block translates the virtual address to a physical address.
- Reports translation exceptions: refill/miss, invalid, modified.
- Holds the 16 dual-page entries plus the Random register.
- Serves the CP0 TLB instructions TLBWI, TLBWR, TLBP and TLBR.

---
 rtl/mmu_defs.sv | 40 ++++
 rtl/tlb_entry_match.sv | 13 +
 rtl/tlb_unit.sv | 118 +++++++++++
 tb/tb_tlb_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_defs.sv
// mmu_defs: shared TLB field layout, constants and entry types
package mmu_defs;
    localparam int TLB_INDEX_W = 4;
    localparam int TLB_ENTRIES = 16;
    localparam logic [2:0] C_UNCACHED = 3'b010;
    localparam int LO_PFN_HI = 25;
    localparam int LO_PFN_LO = 6;
    localparam int LO_C_HI = 5;
    localparam int LO_C_LO = 3;
    localparam int LO_D = 2;
    localparam int LO_V = 1;
    localparam int LO_G = 0;
    localparam int HI_VPN2_HI = 31;
    localparam int HI_VPN2_LO = 13;
    localparam int HI_ASID_HI = 7;
    localparam int HI_ASID_LO = 0;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    function automatic tlb_page_t lo_to_page(input logic [LO_PFN_HI:LO_V] f);
        return {f[LO_PFN_HI:LO_PFN_LO], f[LO_C_HI:LO_C_LO], f[LO_D], f[LO_V]};
    endfunction

    function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
        return {6'b0, p.pfn, p.c, p.d, p.v, g};
    endfunction
endpackage

// File: rtl/tlb_entry_match.sv
// tlb_entry_match: hit when VPN2 matches and the entry is global or ASIDs agree
module tlb_entry_match
    import mmu_defs::*;
(
    input  logic [18:0] entry_vpn2,
    input  logic [7:0]  entry_asid,
    input  logic        entry_g,
    input  logic [18:0] vpn2,
    input  logic [7:0]  asid,
    output logic        hit
);
    assign hit = (entry_vpn2 == vpn2) && (entry_g || entry_asid == asid);
endmodule

// File: rtl/tlb_unit.sv
// tlb_unit: 16-entry joint TLB with lookup, CP0 TLB instructions and Random
module tlb_unit
    import mmu_defs::*;
#(
    parameter int NUM_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_en,
    input  logic [31:0] lookup_vaddr,
    input  logic        lookup_store,
    input  logic [7:0]  asid_i,
    output logic [31:0] paddr_o,
    output logic        tlb_miss,
    output logic        tlb_invalid,
    output logic        tlb_modified,
    output logic        tlb_uncached,
    input  logic        tlbwi,
    input  logic        tlbwr,
    input  logic        tlbp,
    input  logic        tlbr,
    input  logic [3:0]  index_i,
    input  logic [3:0]  wired_i,
    input  logic        wired_we,
    input  logic [31:0] entryhi_i,
    input  logic [31:0] entrylo0_i,
    input  logic [31:0] entrylo1_i,
    output logic [31:0] probe_o,
    output logic [31:0] entryhi_o,
    output logic [31:0] entrylo0_o,
    output logic [31:0] entrylo1_o,
    output logic [3:0]  random_o
);
    tlb_entry_t tlb [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] l_vec, p_vec;
    logic [TLB_INDEX_W-1:0] l_idx, p_idx, wr_idx;
    logic l_hit, p_hit, l_ok;
    tlb_entry_t wr_entry, sel, rd_e;
    tlb_page_t pg;
    logic unused_bits;

    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};

    genvar g;
    generate
        for (g = 0; g < NUM_ENTRIES; g++) begin : g_match
            tlb_entry_match u_lookup (
                .entry_vpn2(tlb[g].vpn2), .entry_asid(tlb[g].asid), .entry_g(tlb[g].g),
                .vpn2(lookup_vaddr[31:13]), .asid(asid_i), .hit(l_vec[g])
            );
            tlb_entry_match u_probe (
                .entry_vpn2(tlb[g].vpn2), .entry_asid(tlb[g].asid), .entry_g(tlb[g].g),
                .vpn2(entryhi_i[HI_VPN2_HI:HI_VPN2_LO]), .asid(entryhi_i[HI_ASID_HI:HI_ASID_LO]),
                .hit(p_vec[g])
            );
        end
    endgenerate

    // priority encoders: the lowest matching index wins
    always_comb begin
        l_idx = '0;
        p_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (l_vec[i]) l_idx = i[TLB_INDEX_W-1:0];
            if (p_vec[i]) p_idx = i[TLB_INDEX_W-1:0];
        end
    end

    assign l_hit = |l_vec;
    assign p_hit = |p_vec;
    assign sel   = tlb[l_idx];
    assign pg    = lookup_vaddr[12] ? sel.p1 : sel.p0;
    assign l_ok  = lookup_en && l_hit;

    assign paddr_o      = l_ok ? {pg.pfn, lookup_vaddr[11:0]} : 32'h0;
    assign tlb_miss     = lookup_en && !l_hit;
    assign tlb_invalid  = l_ok && !pg.v;
    assign tlb_modified = l_ok && pg.v && lookup_store && !pg.d;
    assign tlb_uncached = l_ok && pg.c == C_UNCACHED;

    assign wr_idx   = tlbwi ? index_i : random_o;
    assign wr_entry = {entryhi_i[HI_VPN2_HI:HI_VPN2_LO], entryhi_i[HI_ASID_HI:HI_ASID_LO],
                       entrylo0_i[LO_G] & entrylo1_i[LO_G],
                       lo_to_page(entrylo0_i[LO_PFN_HI:LO_V]), lo_to_page(entrylo1_i[LO_PFN_HI:LO_V])};
    assign rd_e     = tlb[index_i];

    // entry storage: TLBWI/TLBWR write at the clock edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) tlb[i] <= '0;
        end else if (tlbwi || tlbwr) begin
            tlb[wr_idx] <= wr_entry;
        end
    end

    // registered TLBP/TLBR results, held until the next request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            probe_o    <= '0;
            entryhi_o  <= '0;
            entrylo0_o <= '0;
            entrylo1_o <= '0;
        end else begin
            if (tlbp) probe_o <= p_hit ? {28'b0, p_idx} : 32'h8000_0000;
            if (tlbr) begin
                entryhi_o  <= {rd_e.vpn2, 5'b0, rd_e.asid};
                entrylo0_o <= page_to_lo(rd_e.p0, rd_e.g);
                entrylo1_o <= page_to_lo(rd_e.p1, rd_e.g);
            end
        end
    end

    // Random counts down from 15 to Wired, then wraps back to 15
    always_ff @(posedge clk) begin
        if (!rst_n || wired_we || random_o == wired_i) random_o <= 4'd15;
        else random_o <= random_o - 4'd1;
    end
endmodule

// File: tb/tb_tlb_unit.sv
// tb_tlb_unit: directed scoreboard bench for tlb_unit
module tb_tlb_unit;
    logic        clk = 0, rst_n = 0;
    logic        lookup_en = 0, lookup_store = 0;
    logic [31:0] lookup_vaddr = 0;
    logic [7:0]  asid_i = 0;
    logic [31:0] paddr_o;
    logic        tlb_miss, tlb_invalid, tlb_modified, tlb_uncached;
    logic        tlbwi = 0, tlbwr = 0, tlbp = 0, tlbr = 0, wired_we = 0;
    logic [3:0]  index_i = 0, wired_i = 0, random_o;
    logic [31:0] entryhi_i = 0, entrylo0_i = 0, entrylo1_i = 0;
    logic [31:0] probe_o, entryhi_o, entrylo0_o, entrylo1_o;
    logic        tlbp_d = 0, tlbr_d = 0, rnd_chk = 0, chk_regs = 0;
    int          vectors = 0, fails = 0;

    typedef struct { string name; logic [95:0] v; } exp_t;
    exp_t lq[$], pq[$], rq[$], nq[$];

    tlb_unit #(.NUM_ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_en(lookup_en), .lookup_vaddr(lookup_vaddr),
        .lookup_store(lookup_store), .asid_i(asid_i), .paddr_o(paddr_o), .tlb_miss(tlb_miss),
        .tlb_invalid(tlb_invalid), .tlb_modified(tlb_modified), .tlb_uncached(tlb_uncached),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr), .index_i(index_i),
        .wired_i(wired_i), .wired_we(wired_we), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
        .entrylo1_i(entrylo1_i), .probe_o(probe_o), .entryhi_o(entryhi_o),
        .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o), .random_o(random_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tlbp_d <= tlbp;
        tlbr_d <= tlbr;
    end

    task automatic cmp(input exp_t e, input logic [95:0] act);
        vectors++;
        if (act !== e.v) begin
            fails++;
            $display("FAIL %s: got %h want %h", e.name, act, e.v);
        end
    endtask

    task automatic none(input string kind);
        vectors++;
        fails++;
        $display("FAIL %s: output presented with no expectation queued", kind);
    endtask

    // monitor: pop and compare whenever an output is presented
    always @(negedge clk) begin
        if (lookup_en) begin
            if (lq.size() > 0) cmp(lq.pop_front(), {60'b0, paddr_o, tlb_miss, tlb_invalid, tlb_modified, tlb_uncached});
            else none("lookup");
        end
        if (tlbp_d || chk_regs) begin
            if (pq.size() > 0) cmp(pq.pop_front(), {64'b0, probe_o});
            else none("probe");
        end
        if (tlbr_d || chk_regs) begin
            if (rq.size() > 0) cmp(rq.pop_front(), {entryhi_o, entrylo0_o, entrylo1_o});
            else none("tlbr");
        end
        if (rnd_chk) begin
            if (nq.size() > 0) cmp(nq.pop_front(), {92'b0, random_o});
            else none("random");
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        {lookup_en, lookup_store, tlbwi, tlbwr, tlbp, tlbr, wired_we, rnd_chk, chk_regs} = '0;
    endtask

    task automatic lk(input string n, input logic [31:0] va, input logic st, input logic [31:0] pa,
                      input logic m, input logic iv, input logic md, input logic u);
        lookup_en = 1;
        lookup_vaddr = va;
        lookup_store = st;
        lq.push_back('{n, {60'b0, pa, m, iv, md, u}});
    endtask

    task automatic wr(input logic wi, input logic wrr, input logic [3:0] idx,
                      input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        tlbwi = wi;
        tlbwr = wrr;
        index_i = idx;
        entryhi_i = hi;
        entrylo0_i = lo0;
        entrylo1_i = lo1;
    endtask

    task automatic pr(input string n, input logic [31:0] hi, input logic [31:0] exp);
        tlbp = 1;
        entryhi_i = hi;
        pq.push_back('{n, {64'b0, exp}});
    endtask

    task automatic rd(input string n, input logic [3:0] idx, input logic [31:0] hi,
                      input logic [31:0] lo0, input logic [31:0] lo1);
        tlbr = 1;
        index_i = idx;
        rq.push_back('{n, {hi, lo0, lo1}});
    endtask

    task automatic rchk(input string n, input logic [3:0] v);
        rnd_chk = 1;
        nq.push_back('{n, {92'b0, v}});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        cyc();
        cyc();
        asid_i = 8'd5;
        chk_regs = 1;
        pq.push_back('{"reset_probe", 96'h0});
        rq.push_back('{"reset_regs", 96'h0});
        rchk("reset_random", 4'd15);
        lk("reset_lookup_miss", 32'h0040_0000, 0, 32'h0, 1, 0, 0, 0);
        cyc();
        rst_n = 1;
        wr(1, 0, 4'd3, 32'h0040_0005, 32'h0000_1016, 32'h0000_1042);
        cyc();
        lk("lookup_p0_uncached", 32'h0040_0123, 0, 32'h0004_0123, 0, 0, 0, 1);
        cyc();
        lk("lookup_p1_modified", 32'h0040_1004, 1, 32'h0004_1004, 0, 0, 1, 0);
        cyc();
        lk("lookup_p1_load", 32'h0040_1004, 0, 32'h0004_1004, 0, 0, 0, 0);
        cyc();
        asid_i = 8'd6;
        lk("lookup_asid_miss", 32'h0040_0123, 0, 32'h0, 1, 0, 0, 0);
        cyc();
        wr(1, 0, 4'd3, 32'h0040_0005, 32'h0000_1017, 32'h0000_1043);
        cyc();
        lk("lookup_global_hit", 32'h0040_0123, 0, 32'h0004_0123, 0, 0, 0, 1);
        cyc();
        asid_i = 8'd5;
        pr("probe_hit3", 32'h0040_0005, 32'h0000_0003);
        cyc();
        pr("probe_miss", 32'h1234_0000, 32'h8000_0000);
        cyc();
        cyc();
        wr(1, 0, 4'd1, 32'h0040_0005, 32'h0000_1542, 32'h0000_0002);
        cyc();
        pr("probe_lowest", 32'h0040_0005, 32'h0000_0001);
        lk("lookup_lowest", 32'h0040_0123, 0, 32'h0005_5123, 0, 0, 0, 0);
        cyc();
        wr(1, 0, 4'd2, 32'h0080_0005, 32'h0000_1000, 32'h0);
        cyc();
        lk("lookup_invalid", 32'h0080_0010, 0, 32'h0004_0010, 0, 1, 0, 0);
        cyc();
        lk("lookup_invalid_store", 32'h0080_0010, 1, 32'h0004_0010, 0, 1, 0, 0);
        cyc();
        wired_i = 4'd13;
        wired_we = 1;
        cyc();
        rchk("rnd_a15", 4'd15);
        cyc();
        rchk("rnd_a14", 4'd14);
        cyc();
        rchk("rnd_a13", 4'd13);
        cyc();
        rchk("rnd_wrap15", 4'd15);
        cyc();
        rchk("rnd_b14", 4'd14);
        wired_we = 1;
        cyc();
        rchk("rnd_wired_we15", 4'd15);
        cyc();
        rchk("rnd_tlbwr14", 4'd14);
        wr(0, 1, 4'd0, 32'h00C0_0005, 32'h0000_1DC6, 32'h0000_0002);
        cyc();
        rchk("rnd_c13", 4'd13);
        rd("tlbr_random14", 4'd14, 32'h00C0_0005, 32'h0000_1DC6, 32'h0000_0002);
        cyc();
        rchk("rnd_c15", 4'd15);
        wr(1, 1, 4'd5, 32'h0100_0005, 32'h0000_0002, 32'h0000_0002);
        cyc();
        rd("tlbr_idx15_untouched", 4'd15, 32'h0, 32'h0, 32'h0);
        cyc();
        rd("tlbr_tlbwi_wins", 4'd5, 32'h0100_0005, 32'h0000_0002, 32'h0000_0002);
        cyc();
        wired_i = 4'd15;
        wired_we = 1;
        cyc();
        rchk("rnd_w15_a", 4'd15);
        cyc();
        rchk("rnd_w15_b", 4'd15);
        cyc();
        rchk("rnd_w15_c", 4'd15);
        cyc();
        wr(1, 0, 4'd3, 32'h00A0_1F07, 32'h0000_2006, 32'h0000_2046);
        rd("tlbr_old", 4'd3, 32'h0040_0005, 32'h0000_1017, 32'h0000_1043);
        cyc();
        rd("tlbr_new", 4'd3, 32'h00A0_0007, 32'h0000_2006, 32'h0000_2046);
        cyc();
        rst_n = 0;
        wr(1, 0, 4'd7, 32'h00A0_0007, 32'h0000_0002, 32'h0000_0002);
        tlbp = 1;
        tlbr = 1;
        index_i = 4'd3;
        pq.push_back('{"midreset_probe", 96'h0});
        rq.push_back('{"midreset_tlbr", 96'h0});
        cyc();
        rst_n = 1;
        rchk("midreset_random", 4'd15);
        cyc();
        rd("midreset_entry7", 4'd7, 32'h0, 32'h0, 32'h0);
        lk("midreset_lookup_miss", 32'h0040_0123, 0, 32'h0, 1, 0, 0, 0);
        cyc();
        cyc();
        cyc();
        vectors++;
        if (lq.size() + pq.size() + rq.size() + nq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0",
                     lq.size() + pq.size() + rq.size() + nq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
